// File: rtl/npc_pkg.sv
// Shared constants and the next-PC source encoding for the MIPS next-PC path.
package npc_pkg;

   localparam int PC_W    = 32;
   localparam int IMM16_W = 16;
   localparam int IMM26_W = 26;

   localparam logic [PC_W-1:0] PC_INC      = 32'd4;
   localparam logic [PC_W-1:0] RESET_PC_DEF = 32'h0000_0000;

   typedef enum logic [1:0] {
      NPC_SEQ    = 2'd0,
      NPC_BRANCH = 2'd1,
      NPC_JUMP   = 2'd2
   } npc_src_e;

endpackage : npc_pkg

// File: rtl/npc_target_gen.sv
// Combinational generation of the three candidate next-PC byte addresses.
module npc_target_gen
   import npc_pkg::*;
#(
   parameter int IM_AW = 10
) (
   input  logic [IM_AW-1:0]   im_addr_i,
   input  logic [IMM16_W-1:0] imm16_i,
   input  logic [IMM26_W-1:0] imm26_i,
   output logic [PC_W-1:0]    pc_plus4_o,
   output logic [PC_W-1:0]    br_tgt_o,
   output logic [PC_W-1:0]    j_tgt_o
);

   logic [PC_W-1:0] pcCur;
   logic [PC_W-1:0] brOffset;

   // Full 32-bit arithmetic: the top IM word wraps into bit IM_AW+2, not to zero.
   assign pcCur      = {{(PC_W-IM_AW-2){1'b0}}, im_addr_i, 2'b00};
   assign pc_plus4_o = pcCur + PC_INC;

   assign brOffset = {{(PC_W-IMM16_W-2){imm16_i[IMM16_W-1]}}, imm16_i, 2'b00};
   assign br_tgt_o = pc_plus4_o + brOffset;

   assign j_tgt_o  = {pc_plus4_o[PC_W-1:PC_W-4], imm26_i, 2'b00};

endmodule : npc_target_gen

// File: rtl/next_pc_calculator.sv
// Selects sequential, BEQ or jump target and registers it as the next PC.
module next_pc_calculator
   import npc_pkg::*;
#(
   parameter int              IM_AW    = 10,
   parameter logic [PC_W-1:0] RESET_PC = RESET_PC_DEF
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [IMM16_W-1:0]  npc_in_imm16,
   input  logic [IMM26_W-1:0]  npc_in_imm26,
   input  logic [IM_AW-1:0]    im_out_addr,
   input  logic                npc_sel,
   input  logic                alu_zero,
   input  logic                isJump,
   output logic [PC_W-1:0]     npc_out_addr
);

   logic [PC_W-1:0] pcPlus4;
   logic [PC_W-1:0] brTgt;
   logic [PC_W-1:0] jTgt;
   npc_src_e        npcSrc;
   logic [PC_W-1:0] npc_d;
   logic [PC_W-1:0] npc_q;

   npc_target_gen #(
      .IM_AW(IM_AW)
   ) u_target_gen (
      .im_addr_i (im_out_addr),
      .imm16_i   (npc_in_imm16),
      .imm26_i   (npc_in_imm26),
      .pc_plus4_o(pcPlus4),
      .br_tgt_o  (brTgt),
      .j_tgt_o   (jTgt)
   );

   // Jump outranks a simultaneously taken branch.
   always_comb begin
      npcSrc = NPC_SEQ;
      if (isJump) begin
         npcSrc = NPC_JUMP;
      end else if (npc_sel && alu_zero) begin
         npcSrc = NPC_BRANCH;
      end
   end

   always_comb begin
      npc_d = pcPlus4;
      case (npcSrc)
         NPC_JUMP:   npc_d = jTgt;
         NPC_BRANCH: npc_d = brTgt;
         default:    npc_d = pcPlus4;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         npc_q <= RESET_PC;
      end else begin
         npc_q <= npc_d;
      end
   end

   assign npc_out_addr = npc_q;

endmodule : next_pc_calculator

// File: tb/tb_next_pc_calculator.sv
// Directed, table-driven bench for next_pc_calculator plus async-reset sequences.
module tb_next_pc_calculator;

   logic        clk;
   logic        rst_n;
   logic [15:0] npc_in_imm16;
   logic [25:0] npc_in_imm26;
   logic [9:0]  im_out_addr;
   logic        npc_sel;
   logic        alu_zero;
   logic        isJump;
   logic [31:0] npc_out_addr;

   int checks = 0;
   int errors = 0;

   typedef struct {
      string       name;
      logic [9:0]  im;
      logic [15:0] imm16;
      logic [25:0] imm26;
      logic        sel;
      logic        zero;
      logic        jump;
      logic [31:0] exp;
   } vec_t;

   localparam int NVEC = 12;
   vec_t vecs[NVEC];

   next_pc_calculator #(
      .IM_AW   (10),
      .RESET_PC(32'h0000_0000)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .npc_in_imm16(npc_in_imm16),
      .npc_in_imm26(npc_in_imm26),
      .im_out_addr (im_out_addr),
      .npc_sel     (npc_sel),
      .alu_zero    (alu_zero),
      .isJump      (isJump),
      .npc_out_addr(npc_out_addr)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic applyStimulus(input vec_t v);
      im_out_addr  = v.im;
      npc_in_imm16 = v.imm16;
      npc_in_imm26 = v.imm26;
      npc_sel      = v.sel;
      alu_zero     = v.zero;
      isJump       = v.jump;
   endtask

   task automatic checkOutput(input string name, input logic [31:0] exp);
      checks++;
      if (npc_out_addr !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, npc_out_addr, exp);
      end
   endtask

   initial begin
      vecs[0]  = '{"seq_pc0",        10'd0,     16'h0024, 26'h0000000, 1'b0, 1'b0, 1'b0, 32'h0000_0004};
      vecs[1]  = '{"seq_top_word",   10'h3FF,   16'h0024, 26'h0000000, 1'b0, 1'b0, 1'b0, 32'h0000_1000};
      vecs[2]  = '{"beq_taken",      10'd0,     16'h0024, 26'h0000000, 1'b1, 1'b1, 1'b0, 32'h0000_0094};
      vecs[3]  = '{"beq_not_taken",  10'd0,     16'h0024, 26'h0000000, 1'b1, 1'b0, 1'b0, 32'h0000_0004};
      vecs[4]  = '{"beq_negative",   10'd10,    16'hFFFE, 26'h0000000, 1'b1, 1'b1, 1'b0, 32'h0000_0024};
      vecs[5]  = '{"zero_no_sel",    10'd5,     16'h0024, 26'h0000000, 1'b0, 1'b1, 1'b0, 32'h0000_0018};
      vecs[6]  = '{"beq_wrap_neg",   10'd0,     16'h8000, 26'h0000000, 1'b1, 1'b1, 1'b0, 32'hFFFE_0004};
      vecs[7]  = '{"beq_max_pos",    10'd1,     16'h7FFF, 26'h0000000, 1'b1, 1'b1, 1'b0, 32'h0002_0004};
      vecs[8]  = '{"jump",           10'd0,     16'h0000, 26'h0000002, 1'b0, 1'b0, 1'b1, 32'h0000_0008};
      vecs[9]  = '{"jump_max",       10'h3FF,   16'h0000, 26'h3FFFFFF, 1'b0, 1'b0, 1'b1, 32'h0FFF_FFFC};
      vecs[10] = '{"jump_over_beq",  10'd0,     16'h0024, 26'h0000002, 1'b1, 1'b1, 1'b1, 32'h0000_0008};
      vecs[11] = '{"release_jump",   10'd0,     16'h0024, 26'h0000002, 1'b1, 1'b1, 1'b0, 32'h0000_0094};

      // Reset is asserted between edges so the output must clear with no clock.
      rst_n = 1'b1;
      applyStimulus('{"rst_junk", 10'h155, 16'hABCD, 26'h1234567, 1'b1, 1'b1, 1'b1, 32'h0});
      #1 rst_n = 1'b0;
      #1 checkOutput("reset_async", 32'h0000_0000);
      for (int i = 0; i < 3; i++) begin
         @(posedge clk);
         #1 checkOutput("reset_held", 32'h0000_0000);
      end

      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < NVEC; i++) begin
         applyStimulus(vecs[i]);
         @(posedge clk);
         #1 checkOutput(vecs[i].name, vecs[i].exp);
      end

      // Mid-run reset drops the held 0x94; the first edge after release reloads it.
      @(negedge clk);
      applyStimulus(vecs[5]);
      #1 rst_n = 1'b0;
      #1 checkOutput("reset_mid_run", 32'h0000_0000);
      @(posedge clk);
      #1 checkOutput("reset_discard", 32'h0000_0000);
      @(negedge clk);
      rst_n = 1'b1;
      applyStimulus(vecs[11]);
      #1 checkOutput("reset_release_hold", 32'h0000_0000);
      @(posedge clk);
      #1 checkOutput("reset_release_load", 32'h0000_0094);

      applyStimulus(vecs[4]);
      @(posedge clk);
      #1 checkOutput("post_reset_beq_neg", 32'h0000_0024);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule : tb_next_pc_calculator

// File: doc/next_pc_calculator.md
Name: next_pc_calculator

Overview:
- Computes the MIPS next-PC byte address from the current instruction-memory word address and the decoded control signals.
- Three sources: sequential PC+4, BEQ branch target, J-type jump target.
- Sits between instruction memory (IM) and the PC/IM address path.
- Registered output: the selected next PC is captured on each rising clock edge.

Parameters:
- IM_AW, 10: width of the IM word address (im_out_addr).
- RESET_PC, 32'h0000_0000: value of npc_out_addr while reset is asserted and after release.

Ports:
- clk  input  1  system clock; rising edge active.
- rst_n  input  1  reset, asynchronous, active-low.
- npc_in_imm16  input  16  I-type immediate (branch offset in words, signed).
- npc_in_imm26  input  26  J-type target field.
- im_out_addr  input  IM_AW  current PC as IM word index; byte PC = {zeros, im_out_addr, 2'b00}.
- npc_sel  input  1  instruction is a branch (BEQ).
- alu_zero  input  1  ALU zero flag; BEQ condition is true when it is 1.
- isJump  input  1  instruction is J.
- npc_out_addr  output  32  registered next-PC byte address.

Behaviour:
- Current PC, pc_cur: 32-bit zero-extension of {im_out_addr, 2'b00}.
- Sequential target, pc_plus4: pc_cur + 32'd4, computed at full 32 bits. No truncation to IM_AW+2 bits, so word 0x3FF gives 0x1000.
- Branch target, br_tgt: pc_plus4 + ({{14{imm16[15]}}, imm16, 2'b00}), computed modulo 2^32.
- Jump target, j_tgt: {pc_plus4[31:28], npc_in_imm26, 2'b00}.
- Selection priority, evaluated combinationally:
  - isJump=1 -> j_tgt;
  - else npc_sel=1 and alu_zero=1 -> br_tgt;
  - else -> pc_plus4. This includes npc_sel=1 with alu_zero=0.
- isJump has priority over a simultaneous taken branch.
- npc_out_addr updates on every rising clk edge with the selected value. Latency is 1 cycle from an input change.
- There is no enable or stall; the register loads every cycle.
- Reset:
  - rst_n low forces npc_out_addr = RESET_PC immediately, independent of clk.
  - Reset held across clock edges keeps the output at RESET_PC.
  - Reset asserted mid-operation discards the pending next PC.
  - After release, the first rising edge loads the computed value.
- X-free: all control inputs are decoded as plain 1-bit values. Unknown inputs are the driver's responsibility.
- Bits [1:0] of npc_out_addr are always 0.

Decomposition:
- Shared package npc_pkg holds:
  - constants PC_W=32, IMM16_W=16, IMM26_W=26, PC_INC=32'd4, RESET_PC default;
  - enum npc_src_e {NPC_SEQ, NPC_BRANCH, NPC_JUMP} for the internal select.
- One sub-module, npc_target_gen: purely combinational. It produces pc_plus4, br_tgt and j_tgt, including the imm16 sign extension and shift.
- Top level keeps the priority select and the output register.

Test Plan:
- Reset: rst_n=0 with arbitrary inputs -> npc_out_addr=0x00000000 without a clock edge. It stays there while rst_n=0 across 3 edges.
- Sequential: rst_n=1, im_out_addr=0, npc_sel=0, isJump=0, imm16=0x0024 -> after 1 edge, 0x00000004. With im_out_addr=0x3FF -> 0x00001000.
- Taken BEQ: im_out_addr=0, imm16=0x0024, npc_sel=1, alu_zero=1 -> 0x00000094. Then alu_zero=0 -> 0x00000004.
- Negative offset: im_out_addr=10 (PC 0x28), imm16=0xFFFE, npc_sel=1, alu_zero=1 -> 0x00000024.
- Jump and priority: im_out_addr=0, imm26=0x0000002, isJump=1 -> 0x00000008. Adding npc_sel=1, alu_zero=1, imm16=0x0024 still gives 0x00000008. Releasing isJump -> 0x00000094.
- Async reset mid-run: assert rst_n=0 between edges while the output is 0x94 -> immediate 0x00000000. Deassert -> the next edge loads the current selected value.
